sample_fifo: RTL and testbench

Parametrised synchronous FIFO buffering parallel ADC sample words between the SPI read front end and downstream processing or the host interface.
- Generalises the enabled parallel-in/parallel-out register to Depth entries.
- Adds occupancy reporting, a registered read port with a valid strobe, and sticky overflow/underflow error flags.
- Single clock domain.

---
 rtl/sample_fifo.sv | 82 ++++++++
 tb/tb_sample_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO between the ADC SPI front end and downstream consumers.
// Registered read port with a one-cycle valid strobe and sticky overflow/underflow flags.
module sample_fifo #(
    parameter int Width = 12,
    parameter int Depth = 8,
    localparam int AW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             wr_i,
    input  logic [Width-1:0] din_i,
    input  logic             rd_i,
    output logic [Width-1:0] dout_o,
    output logic             rd_valid_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             ovf_o,
    output logic             udf_o
);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign full_o  = (level_o == (AW+1)'(Depth));
    assign empty_o = (level_o == '0);
    assign rd_ok   = rd_i && !empty_o;
    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign wr_ok   = wr_i && (!full_o || rd_ok);

    always_ff @(posedge clk_i) begin
        if (!rst_i && !clr_i && wr_ok) begin
            mem[wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            dout_o     <= '0;
            rd_valid_o <= 1'b0;
            ovf_o      <= 1'b0;
            udf_o      <= 1'b0;
        end else if (clr_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            dout_o     <= '0;
            rd_valid_o <= 1'b0;
            ovf_o      <= 1'b0;
            udf_o      <= 1'b0;
        end else begin
            rd_valid_o <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                dout_o <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_ok && !rd_ok) begin
                level_o <= level_o + (AW+1)'(1);
            end else if (rd_ok && !wr_ok) begin
                level_o <= level_o - (AW+1)'(1);
            end
            // Error flags are sticky and never block later traffic.
            if (wr_i && !wr_ok) begin
                ovf_o <= 1'b1;
            end
            if (rd_i && !rd_ok) begin
                udf_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
// Bench for sample_fifo (Width=12, Depth=4): directed vector table, a mid-clock
// reset sequence, and random traffic against a queue-based reference model.
module tb_sample_fifo;

    localparam int W = 12;
    localparam int D = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          clr_i = 1'b0;
    logic          wr_i  = 1'b0;
    logic          rd_i  = 1'b0;
    logic [W-1:0]  din_i = '0;
    logic [W-1:0]  dout_o;
    logic          rd_valid_o;
    logic [2:0]    level_o;
    logic          full_o;
    logic          empty_o;
    logic          ovf_o;
    logic          udf_o;

    int check_count = 0;
    int pass_count  = 0;

    sample_fifo #(.Width(W), .Depth(D)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr_i),
        .wr_i       (wr_i),
        .din_i      (din_i),
        .rd_i       (rd_i),
        .dout_o     (dout_o),
        .rd_valid_o (rd_valid_o),
        .level_o    (level_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .ovf_o      (ovf_o),
        .udf_o      (udf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         clr;
        logic         wr;
        logic         rd;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic         valid;
        int           level;
        logic         ovf;
        logic         udf;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: the queue holds the stored words, oldest first.
    logic [W-1:0] model_q[$];
    logic [W-1:0] model_dout;
    logic         model_valid;
    logic         model_ovf;
    logic         model_udf;

    task automatic checkField(input string name, input int unsigned act, input int unsigned exp);
        check_count++;
        if (act == exp) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] dout, input logic valid,
                               input int level, input logic ovf, input logic udf);
        checkField({tag, " dout"}, dout_o, dout);
        checkField({tag, " rd_valid"}, rd_valid_o, valid);
        checkField({tag, " level"}, level_o, level);
        checkField({tag, " full"}, full_o, level == D);
        checkField({tag, " empty"}, empty_o, level == 0);
        checkField({tag, " ovf"}, ovf_o, ovf);
        checkField({tag, " udf"}, udf_o, udf);
    endtask

    // Drive inputs on the falling edge, then return just after the next rising edge.
    task automatic applyStimulus(input logic clr, input logic wr, input logic rd, input logic [W-1:0] din);
        @(negedge clk_i);
        clr_i = clr;
        wr_i  = wr;
        rd_i  = rd;
        din_i = din;
        @(posedge clk_i);
        #1;
    endtask

    function automatic void addVec(input logic clr, input logic wr, input logic rd, input logic [W-1:0] din,
                                   input logic [W-1:0] dout, input logic valid, input int level,
                                   input logic ovf, input logic udf);
        vec_t v;
        v.clr = clr; v.wr = wr; v.rd = rd; v.din = din;
        v.dout = dout; v.valid = valid; v.level = level; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    function automatic void modelStep(input logic clr, input logic wr, input logic rd, input logic [W-1:0] din);
        bit rd_ok;
        bit wr_ok;
        if (clr) begin
            model_q.delete();
            model_dout  = '0;
            model_valid = 1'b0;
            model_ovf   = 1'b0;
            model_udf   = 1'b0;
            return;
        end
        rd_ok = rd && (model_q.size() > 0);
        wr_ok = wr && ((model_q.size() < D) || rd_ok);
        model_valid = rd_ok;
        if (rd_ok) model_dout = model_q.pop_front();
        if (wr_ok) model_q.push_back(din);
        if (wr && !wr_ok) model_ovf = 1'b1;
        if (rd && !rd_ok) model_udf = 1'b1;
    endfunction

    initial begin
        // clr wr rd din | dout valid level ovf udf
        addVec(0,1,0,12'h001, 12'h000,0,1,0,0);
        addVec(0,1,0,12'h002, 12'h000,0,2,0,0);
        addVec(0,1,0,12'h003, 12'h000,0,3,0,0);
        addVec(0,1,0,12'h004, 12'h000,0,4,0,0);
        addVec(0,0,1,12'h000, 12'h001,1,3,0,0);
        addVec(0,0,1,12'h000, 12'h002,1,2,0,0);
        addVec(0,0,1,12'h000, 12'h003,1,1,0,0);
        addVec(0,0,1,12'h000, 12'h004,1,0,0,0);
        addVec(0,0,0,12'h000, 12'h004,0,0,0,0);
        addVec(0,1,0,12'h00A, 12'h004,0,1,0,0);
        addVec(0,1,0,12'h00B, 12'h004,0,2,0,0);
        addVec(0,1,0,12'h00C, 12'h004,0,3,0,0);
        addVec(0,1,0,12'h00D, 12'h004,0,4,0,0);
        addVec(0,1,0,12'hFFF, 12'h004,0,4,1,0);
        addVec(0,0,1,12'h000, 12'h00A,1,3,1,0);
        addVec(0,0,1,12'h000, 12'h00B,1,2,1,0);
        addVec(0,0,1,12'h000, 12'h00C,1,1,1,0);
        addVec(0,0,1,12'h000, 12'h00D,1,0,1,0);
        addVec(0,1,1,12'h123, 12'h00D,0,1,1,1);
        addVec(0,0,1,12'h000, 12'h123,1,0,1,1);
        addVec(1,0,0,12'h000, 12'h000,0,0,0,0);
        addVec(0,1,0,12'h010, 12'h000,0,1,0,0);
        addVec(0,1,0,12'h011, 12'h000,0,2,0,0);
        addVec(0,1,0,12'h012, 12'h000,0,3,0,0);
        addVec(0,1,0,12'h013, 12'h000,0,4,0,0);
        addVec(0,1,1,12'h020, 12'h010,1,4,0,0);
        addVec(0,1,1,12'h021, 12'h011,1,4,0,0);
        addVec(0,1,1,12'h022, 12'h012,1,4,0,0);
        addVec(0,1,1,12'h023, 12'h013,1,4,0,0);
        addVec(0,1,1,12'h024, 12'h020,1,4,0,0);
        addVec(0,1,1,12'h025, 12'h021,1,4,0,0);
        addVec(0,1,0,12'h0FF, 12'h021,0,4,1,0);
        addVec(0,0,1,12'h000, 12'h022,1,3,1,0);
        addVec(1,1,0,12'h0AB, 12'h000,0,0,0,0);
        addVec(0,0,1,12'h000, 12'h000,0,0,0,1);
        addVec(1,0,0,12'h000, 12'h000,0,0,0,0);

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset", 12'h000, 0, 0, 0, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].dout, vecs[i].valid, vecs[i].level,
                        vecs[i].ovf, vecs[i].udf);
        end

        // Mid-clock asynchronous reset with data, dout and a sticky flag all non-zero.
        applyStimulus(0, 1, 0, 12'h5A5);
        applyStimulus(0, 1, 1, 12'h3C3);
        applyStimulus(0, 0, 1, 12'h000);
        applyStimulus(0, 0, 1, 12'h000);
        checkOutput("pre_reset", 12'h3C3, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 12'h777);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("async_reset", 12'h000, 0, 0, 0, 0);
        @(negedge clk_i);
        wr_i  = 1'b0;
        rst_i = 1'b0;
        modelStep(1'b1, 1'b0, 1'b0, '0);

        // Random traffic; write bias alternates so both full and empty are reached often.
        for (int i = 0; i < 800; i++) begin
            logic         c;
            logic         w;
            logic         r;
            logic [W-1:0] d;
            int           wp;
            wp = ((i / 40) % 2 == 0) ? 75 : 25;
            c  = ($urandom_range(0, 63) == 0);
            w  = ($urandom_range(0, 99) < wp);
            r  = ($urandom_range(0, 99) < 50);
            d  = W'($urandom_range(0, 4095));
            applyStimulus(c, w, r, d);
            modelStep(c, w, r, d);
            checkOutput($sformatf("rand%0d", i), model_dout, model_valid, model_q.size(),
                        model_ovf, model_udf);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
